// File: rtl/sprite_fetch_engine.sv
// Pixel-source resolver: scans a sprite register bank in priority order, resolves the
// colour-memory address for a pixel, and fetches it over req/ack. Optional macro SPRITE_FETCH_HFLIP_EN.
module sprite_fetch_engine #(
  parameter int N_SPRITES = 8,
  parameter int SLOT_W    = $clog2(N_SPRITES),
  parameter int COORD_W   = 10,
  parameter int ADDR_W    = 17,
  parameter int SPRITE_W  = 20,
  parameter int SPRITE_H  = 20,
  parameter int SCREEN_W  = 480,
  parameter int SCREEN_H  = 320,
  parameter int BG_ADDR   = 115200
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pixel_valid,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic [COORD_W-1:0] pixel_y,
  output logic               busy,
  output logic [SLOT_W-1:0]  reg_addr,
  input  logic [31:0]        reg_data,
  output logic               mem_req,
  input  logic               mem_ack,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               hit,
  output logic [SLOT_W-1:0]  hit_slot,
  output logic               done,
  output logic               printing_screen,
  output logic               overrun,
  output logic [1:0]         state_dbg
);

  // Handshake: mem_req rises in FETCH and holds mem_addr/hit/hit_slot stable until
  // mem_ack is sampled high; the next cycle drops mem_req and pulses done.
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, FETCH = 2'd2} state_t;

  localparam int CW1   = COORD_W + 1;
  localparam int CNT_W = $clog2(N_SPRITES + 2);

  state_t              state, state_n;
  logic [CNT_W-1:0]    scan_cnt, scan_cnt_n;
  logic [COORD_W-1:0]  px, py, px_n, py_n;
  logic [SLOT_W-1:0]   reg_addr_n, hit_slot_n;
  logic [ADDR_W-1:0]   mem_addr_n;
  logic                hit_n, done_n, printing_n, overrun_n;

  // Slot k's word arrives one cycle after it was selected, so scan_cnt=k+1 compares slot k.
  logic                cmp_valid, slot_hit;
  logic [SLOT_W-1:0]   cmp_slot;
  logic [CW1-1:0]      px_e, py_e, sx, sy, dx, dy, dx_eff;
  logic [8:0]          sprite_id;
  logic [ADDR_W-1:0]   sprite_addr;
  logic                unused_bits;

  assign busy      = (state != IDLE);
  assign mem_req   = (state == FETCH);
  assign state_dbg = state;

  assign cmp_valid = (scan_cnt != '0) && (scan_cnt <= CNT_W'(N_SPRITES));
  assign cmp_slot  = SLOT_W'(scan_cnt - CNT_W'(1));

  assign px_e      = {1'b0, px};
  assign py_e      = {1'b0, py};
  assign sx        = CW1'(reg_data[28:19]);
  assign sy        = CW1'(reg_data[18:9]);
  assign sprite_id = reg_data[8:0];
  assign dx        = px_e - sx;
  assign dy        = py_e - sy;

  // Bounds are evaluated one bit wider than the coordinates so sx+SPRITE_W cannot wrap.
  assign slot_hit = reg_data[31]
                 && (px_e >= sx) && (px_e < sx + CW1'(SPRITE_W))
                 && (py_e >= sy) && (py_e < sy + CW1'(SPRITE_H));

`ifdef SPRITE_FETCH_HFLIP_EN
  assign dx_eff      = reg_data[30] ? (CW1'(SPRITE_W - 1) - dx) : dx;
  assign unused_bits = reg_data[29];
`else
  assign dx_eff      = dx;
  assign unused_bits = ^reg_data[30:29];
`endif

  assign sprite_addr = ADDR_W'(32'(sprite_id) * 32'(SPRITE_W * SPRITE_H)
                             + 32'(dy) * 32'(SPRITE_W) + 32'(dx_eff));

  always_comb begin
    state_n    = state;
    scan_cnt_n = scan_cnt;
    reg_addr_n = reg_addr;
    px_n       = px;
    py_n       = py;
    mem_addr_n = mem_addr;
    hit_n      = hit;
    hit_slot_n = hit_slot;
    done_n     = 1'b0;
    printing_n = printing_screen;
    overrun_n  = overrun;
    case (state)
      IDLE: begin
        if (pixel_valid) begin
          px_n = pixel_x;
          py_n = pixel_y;
          if (({1'b0, pixel_x} < CW1'(SCREEN_W)) && ({1'b0, pixel_y} < CW1'(SCREEN_H))) begin
            printing_n = 1'b1;
            reg_addr_n = '0;
            scan_cnt_n = '0;
            state_n    = SCAN;
          end else begin
            printing_n = 1'b0;
          end
        end
      end
      SCAN: begin
        if (pixel_valid) overrun_n = 1'b1;
        scan_cnt_n = scan_cnt + CNT_W'(1);
        reg_addr_n = (reg_addr == SLOT_W'(N_SPRITES - 1)) ? reg_addr : reg_addr + SLOT_W'(1);
        if (cmp_valid && slot_hit) begin
          mem_addr_n = sprite_addr;
          hit_n      = 1'b1;
          hit_slot_n = cmp_slot;
          state_n    = FETCH;
        end else if (scan_cnt == CNT_W'(N_SPRITES + 1)) begin
          mem_addr_n = ADDR_W'(BG_ADDR);
          hit_n      = 1'b0;
          hit_slot_n = '0;
          state_n    = FETCH;
        end
      end
      FETCH: begin
        if (pixel_valid) overrun_n = 1'b1;
        if (mem_ack) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      scan_cnt        <= '0;
      px              <= '0;
      py              <= '0;
      reg_addr        <= '0;
      mem_addr        <= '0;
      hit             <= 1'b0;
      hit_slot        <= '0;
      done            <= 1'b0;
      printing_screen <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      state           <= state_n;
      scan_cnt        <= scan_cnt_n;
      px              <= px_n;
      py              <= py_n;
      reg_addr        <= reg_addr_n;
      mem_addr        <= mem_addr_n;
      hit             <= hit_n;
      hit_slot        <= hit_slot_n;
      done            <= done_n;
      printing_screen <= printing_n;
      overrun         <= overrun_n;
    end
  end

endmodule

// File: tb/tb_sprite_fetch_engine.sv
// Self-checking bench for sprite_fetch_engine: directed pixels against a priority-scan model
// of the sprite bank, plus literal addresses and cycle positions worked out by hand.
module tb_sprite_fetch_engine;
  localparam int N  = 8;
  localparam int SW = 3;
  localparam int AW = 17;
  localparam int EW = 1 + SW + AW;
`ifdef SPRITE_FETCH_HFLIP_EN
  localparam int FLIP_ADDR = 1254;
`else
  localparam int FLIP_ADDR = 1245;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          pixel_valid;
  logic [9:0]    pixel_x, pixel_y;
  logic          busy;
  logic [SW-1:0] reg_addr;
  logic [31:0]   reg_data = '0;
  logic          mem_req, mem_ack;
  logic [AW-1:0] mem_addr;
  logic          hit;
  logic [SW-1:0] hit_slot;
  logic          done, printing_screen, overrun;
  logic [1:0]    state_dbg;

  logic [31:0]   bank [N];
  logic [EW-1:0] exp_q [$];
  int            total = 0;
  int            bad   = 0;

  sprite_fetch_engine dut (
    .clk(clk), .reset(reset), .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .busy(busy), .reg_addr(reg_addr), .reg_data(reg_data), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_addr(mem_addr), .hit(hit), .hit_slot(hit_slot), .done(done),
    .printing_screen(printing_screen), .overrun(overrun), .state_dbg(state_dbg)
  );

  // clock / reset / register bank with one-cycle read latency
  always #5 clk = ~clk;
  always @(posedge clk) reg_data <= bank[reg_addr];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] slot_word(input bit en, input bit flip, input int x,
                                            input int y, input int id);
    logic [9:0] xv, yv;
    logic [8:0] iv;
    xv = x[9:0];
    yv = y[9:0];
    iv = id[8:0];
    return {en, flip, 1'b0, xv, yv, iv};
  endfunction

  // First enabled sprite (lowest slot) covering the pixel, else the background.
  function automatic logic [EW-1:0] model(input int px, input int py);
    for (int i = 0; i < N; i++) begin
      logic [31:0] w;
      int sx, sy, id, dx, dy, addr;
      w  = bank[i];
      sx = int'(w[28:19]);
      sy = int'(w[18:9]);
      id = int'(w[8:0]);
      if (w[31] && px >= sx && px < sx + 20 && py >= sy && py < sy + 20) begin
        dx = px - sx;
        dy = py - sy;
`ifdef SPRITE_FETCH_HFLIP_EN
        if (w[30]) dx = 19 - dx;
`endif
        addr = (id * 400 + dy * 20 + dx) % 131072;
        return {1'b1, SW'(i), AW'(addr)};
      end
    end
    return {1'b0, SW'(0), AW'(115200)};
  endfunction

  // scoreboard: every cycle with mem_req high must match the oldest expected transaction
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (mem_req) begin
        if (exp_q.size() == 0) check("unexpected_req", 1, 0);
        else begin
          check("hit", int'(hit), int'(exp_q[0][EW-1]));
          if (exp_q[0][EW-1]) check("hit_slot", int'(hit_slot), int'(exp_q[0][EW-2 -: SW]));
          check("mem_addr", int'(mem_addr), int'(exp_q[0][AW-1:0]));
        end
      end
      if (done && exp_q.size() > 0) void'(exp_q.pop_front());
    end
  end

  // driver: pixel in cycle 0, then cycle positions of mem_req and done are recorded
  task automatic run_txn(input bit now, input int x, input int y, input int exp_req,
                         input int exp_done, input int exp_addr);
    int req_n, done_n, addr_at;
    int busy_seen;
    if (!now) @(negedge clk);
    pixel_x = x[9:0];
    pixel_y = y[9:0];
    pixel_valid = 1'b1;
    if (exp_req > 0) exp_q.push_back(model(x, y));
    req_n = -1; done_n = -1; addr_at = -1; busy_seen = 0;
    for (int n = 1; n <= 30 && done_n < 0; n++) begin
      @(negedge clk);
      pixel_valid = 1'b0;
      if (busy) busy_seen = 1;
      if (mem_req && req_n < 0) begin
        req_n = n;
        addr_at = int'(mem_addr);
      end
      if (done && done_n < 0) done_n = n;
    end
    if (exp_req > 0) begin
      check("req_cycle", req_n, exp_req);
      check("done_cycle", done_n, exp_done);
      check("addr_literal", addr_at, exp_addr);
      check("printing_on", int'(printing_screen), 1);
    end else begin
      check("no_req", req_n, -1);
      check("busy_idle", busy_seen, 0);
      check("printing_off", int'(printing_screen), 0);
    end
  endtask

  task automatic clear_bank();
    for (int i = 0; i < N; i++) bank[i] = '0;
  endtask

  initial begin
    int req_seen;
    clear_bank();
    reset = 1'b0; pixel_valid = 1'b0; pixel_x = '0; pixel_y = '0; mem_ack = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_mem_req", int'(mem_req), 0);
    check("rst_hit", int'(hit), 0);
    check("rst_done", int'(done), 0);
    check("rst_printing", int'(printing_screen), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_reg_addr", int'(reg_addr), 0);
    check("rst_hit_slot", int'(hit_slot), 0);
    check("rst_mem_addr", int'(mem_addr), 0);
    reset = 1'b1;

    bank[2] = slot_word(1, 0, 100, 50, 3);
    run_txn(0, 105, 52, 5, 6, 1245);
    run_txn(0, 119, 69, 5, 6, 1599);
    run_txn(1, 120, 50, 11, 12, 115200);   // accepted in the done cycle
    run_txn(0, 480, 10, 0, 0, 0);
    run_txn(0, 10, 320, 0, 0, 0);

    bank[1] = slot_word(1, 0, 100, 50, 1);
    bank[4] = slot_word(1, 0, 95, 40, 6);
    run_txn(0, 105, 52, 4, 5, 445);
    bank[1] = '0; bank[2] = '0;
    run_txn(0, 105, 52, 7, 8, 2650);

    clear_bank();
    bank[0] = slot_word(1, 0, 0, 0, 5);
    bank[7] = slot_word(1, 0, 460, 300, 2);
    run_txn(0, 19, 19, 3, 4, 2399);
    run_txn(0, 479, 319, 10, 11, 1199);
    bank[3] = slot_word(0, 0, 100, 50, 3);
    bank[6] = slot_word(1, 0, 100, 50, 7);
    run_txn(0, 105, 52, 9, 10, 2845);

    clear_bank();
    bank[2] = slot_word(1, 1, 100, 50, 3);
    run_txn(0, 105, 52, 5, 6, FLIP_ADDR);
    check("overrun_clear", int'(overrun), 0);

    // slow memory with a stray pixel during FETCH
    bank[2] = slot_word(1, 0, 100, 50, 3);
    @(negedge clk);
    mem_ack = 1'b0;
    pixel_x = 10'd105; pixel_y = 10'd52; pixel_valid = 1'b1;
    exp_q.push_back(model(105, 52));
    req_seen = 0;
    for (int n = 0; n < 20 && !req_seen; n++) begin
      @(negedge clk);
      pixel_valid = 1'b0;
      if (mem_req) req_seen = 1;
    end
    check("slow_req_seen", req_seen, 1);
    for (int i = 0; i < 4; i++) begin
      check("hold_req", int'(mem_req), 1);
      check("hold_addr", int'(mem_addr), 1245);
      pixel_valid = (i == 1);
      pixel_x = 10'd3; pixel_y = 10'd3;
      @(negedge clk);
    end
    pixel_valid = 1'b0;
    mem_ack = 1'b1;
    @(negedge clk);
    check("slow_done", int'(done), 1);
    check("slow_req_drop", int'(mem_req), 0);
    check("slow_idle", int'(busy), 0);
    check("overrun_set", int'(overrun), 1);

    // reset in the middle of FETCH
    mem_ack = 1'b0;
    @(negedge clk);
    pixel_x = 10'd105; pixel_y = 10'd52; pixel_valid = 1'b1;
    exp_q.push_back(model(105, 52));
    req_seen = 0;
    for (int n = 0; n < 20 && !req_seen; n++) begin
      @(negedge clk);
      pixel_valid = 1'b0;
      if (mem_req) req_seen = 1;
    end
    check("rst_fetch_req_seen", req_seen, 1);
    #1 reset = 1'b0;
    #1;
    check("rst_fetch_req", int'(mem_req), 0);
    check("rst_fetch_busy", int'(busy), 0);
    check("rst_fetch_overrun", int'(overrun), 0);
    check("rst_fetch_mem_addr", int'(mem_addr), 0);
    exp_q.delete();
    mem_ack = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_txn(0, 105, 52, 5, 6, 1245);

    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within its time limit");
    $fatal(1, "timeout");
  end

endmodule
